rst_seq: RTL and testbench

Reset sequencer: the issuing end of the board's reset distribution. After the synchronized system reset releases, or after a fault/watchdog/button reset request, it holds every downstream block in reset for a minimum pulse width. It then releases the per-block active-low resets one stage at a time in a fixed order, e.g. sensor interface, then balance controller, then motor drive. It sits just after reset synchronization and feeds the `rst_n` inputs of the datapath blocks.

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_seq_if.sv | 29 ++
 rtl/rst_seq_cnt.sv | 28 ++
 rtl/rst_seq.sv | 122 ++++++++++++
 tb/tb_rst_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and defaults for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        HOLD,
        RAMP,
        RUN
    } seq_state_t;

    localparam int REQ_CNT_W         = 8;
    localparam int DEF_NUM_STAGES    = 3;
    localparam int DEF_MIN_PULSE     = 8;
    localparam int DEF_STAGE_DLY     = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// rtl/rst_seq_if.sv - request input and sequenced reset outputs of rst_seq
interface rst_seq_if #(
    parameter int NUM_STAGES = 3
);
    import rst_seq_pkg::*;

    logic                  req_rst;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  all_released;
    logic                  busy;
    logic [REQ_CNT_W-1:0]  req_cnt;

    modport master (
        input  req_rst,
        output stage_rst_n,
        output all_released,
        output busy,
        output req_cnt
    );

    modport slave (
        output req_rst,
        input  stage_rst_n,
        input  all_released,
        input  busy,
        input  req_cnt
    );

endinterface

// File: rtl/rst_seq_cnt.sv
// rtl/rst_seq_cnt.sv - loadable up-counter with terminal-count compare
module rst_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    // Clear loads 1 so the edge that leaves a phase already counts as its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= W'(1);
        end else if (clr) begin
            cnt_q <= W'(1);
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - reset sequencer: minimum pulse, then in-order stage release
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int MIN_PULSE  = DEF_MIN_PULSE,
    parameter int STAGE_DLY  = DEF_STAGE_DLY
) (
    input  logic         clk,
    input  logic         rst,
    rst_seq_if.master    bus
);

    localparam int CNT_W = $clog2(max2(MIN_PULSE, STAGE_DLY) + 1);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

    seq_state_t            state_q, state_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  all_rel_q, busy_q, req_prev_q;
    logic [REQ_CNT_W-1:0]  req_cnt_q;
    logic                  cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0]      cnt_tc_val;
    logic                  last_stage;

    assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));

    rst_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (cnt_tc_val),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ASSERT;
            stage_q    <= '0;
            idx_q      <= '0;
            all_rel_q  <= 1'b0;
            busy_q     <= 1'b1;
            req_prev_q <= 1'b0;
            req_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            idx_q      <= idx_d;
            all_rel_q  <= &stage_d;
            busy_q     <= ~&stage_d;
            req_prev_q <= bus.req_rst;
            if (bus.req_rst && !req_prev_q && (req_cnt_q != '1)) begin
                req_cnt_q <= req_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.req_rst) begin
            state_d = ASSERT;
        end else begin
            case (state_q)
                ASSERT: state_d = HOLD;
                HOLD:   if (cnt_tc) state_d = (NUM_STAGES == 1) ? RUN : RAMP;
                RAMP:   if (cnt_tc && last_stage) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // A request overrides every phase and throws away partial progress.
    always_comb begin
        stage_d    = stage_q;
        idx_d      = idx_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        cnt_tc_val = CNT_W'(MIN_PULSE);
        if (bus.req_rst) begin
            stage_d = '0;
            idx_d   = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ASSERT: begin
                    stage_d = '0;
                    cnt_clr = 1'b1;
                end
                HOLD: begin
                    if (cnt_tc) begin
                        stage_d = STAGE_ONE;
                        idx_d   = IDX_W'(1);
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                RAMP: begin
                    cnt_tc_val = CNT_W'(STAGE_DLY);
                    if (cnt_tc) begin
                        stage_d = stage_q | (STAGE_ONE << idx_q);
                        idx_d   = idx_q + 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    stage_d = stage_q;
                end
            endcase
        end
    end

    assign bus.stage_rst_n  = stage_q;
    assign bus.all_released = all_rel_q;
    assign bus.busy         = busy_q;
    assign bus.req_cnt      = req_cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - randomized bench for rst_seq against a release-time model
module tb_rst_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_rst = 1'b0;
    bit   chk_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    localparam int N0 = 3, P0 = 8, D0 = 16;
    localparam int N1 = 1, P1 = 1, D1 = 1;
    localparam int N2 = 8, P2 = 2, D2 = 1;

    always #5 clk = ~clk;

    rst_seq_if #(.NUM_STAGES(N0)) i0 ();
    rst_seq_if #(.NUM_STAGES(N1)) i1 ();
    rst_seq_if #(.NUM_STAGES(N2)) i2 ();

    assign i0.req_rst = req_rst;
    assign i1.req_rst = req_rst;
    assign i2.req_rst = req_rst;

    rst_seq #(.NUM_STAGES(N0), .MIN_PULSE(P0), .STAGE_DLY(D0)) dut0 (.clk(clk), .rst(rst), .bus(i0));
    rst_seq #(.NUM_STAGES(N1), .MIN_PULSE(P1), .STAGE_DLY(D1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
    rst_seq #(.NUM_STAGES(N2), .MIN_PULSE(P2), .STAGE_DLY(D2)) dut2 (.clk(clk), .rst(rst), .bus(i2));

    // t = edges since the reset cause dropped (0 at E0, -1 while a cause is held)
    int t_quiet = -1;
    int m_cnt = 0;
    bit m_prev = 1'b0;

    always @(posedge clk) begin
        if (rst || req_rst) t_quiet <= -1;
        else if (t_quiet < 100000) t_quiet <= t_quiet + 1;
        if (rst) begin
            m_cnt  <= 0;
            m_prev <= 1'b0;
        end else begin
            m_prev <= req_rst;
            if (req_rst && !m_prev && m_cnt < 255) m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [31:0] exp_stage(input int n, input int mp, input int sd, input int t);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++)
            if (t >= 0 && t >= mp + k * sd) r[k] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic chk_dut(input string tag, input int n, input int mp, input int sd,
                           input logic [31:0] st, input logic ar, input logic bz,
                           input logic [7:0] rc);
        logic [31:0] es, mask;
        es   = exp_stage(n, mp, sd, t_quiet);
        mask = (32'd1 << n) - 32'd1;
        chk({tag, "_stage"}, st, es);
        chk({tag, "_all_rel"}, 32'(ar), 32'(es == mask));
        chk({tag, "_busy"}, 32'(bz), 32'(es != mask));
        chk({tag, "_req_cnt"}, 32'(rc), 32'(m_cnt));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk_dut("d0", N0, P0, D0, 32'(i0.stage_rst_n), i0.all_released, i0.busy, i0.req_cnt);
            chk_dut("d1", N1, P1, D1, 32'(i1.stage_rst_n), i1.all_released, i1.busy, i1.req_cnt);
            chk_dut("d2", N2, P2, D2, 32'(i2.stage_rst_n), i2.all_released, i2.busy, i2.req_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        step(1);
        chk_en = 1'b1;
        chk("rst_stage", 32'(i0.stage_rst_n), 32'd0);
        chk("rst_busy", 32'(i0.busy), 32'd1);
        step(4);
        rst = 1'b0;
        step(60);
        chk("pwr_up_done", 32'(i0.stage_rst_n), 32'h7);

        req_rst = 1'b1;
        step(1);
        req_rst = 1'b0;
        chk("req_resp", 32'(i0.stage_rst_n), 32'd0);
        step(60);

        // Pulse, then a second pulse 3 cycles after stage 0 comes out of reset.
        req_rst = 1'b1;
        step(1);
        req_rst = 1'b0;
        step(12);
        chk("mid_ramp_pre", 32'(i0.stage_rst_n), 32'h1);
        req_rst = 1'b1;
        step(1);
        req_rst = 1'b0;
        chk("mid_ramp_kill", 32'(i0.stage_rst_n), 32'd0);
        step(60);

        req_rst = 1'b1;
        step(50);
        req_rst = 1'b0;
        step(60);

        repeat (40) begin
            rst     = ($urandom_range(0, 9) == 0);
            req_rst = $urandom_range(0, 1);
            step($urandom_range(1, 6));
            rst     = 1'b0;
            req_rst = 1'b0;
            step($urandom_range(0, 50));
        end

        repeat (300) begin
            req_rst = 1'b1;
            step(1);
            req_rst = 1'b0;
            step(1);
        end
        chk("sat_cnt", 32'(i0.req_cnt), 32'd255);

        rst = 1'b1;
        req_rst = 1'b1;
        step(2);
        chk("prio_cnt", 32'(i0.req_cnt), 32'd0);
        chk("prio_stage", 32'(i0.stage_rst_n), 32'd0);
        rst = 1'b0;
        req_rst = 1'b0;
        step(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
